// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite master: response codes, FSM states and
// command/response records.
package axil_pkg;

  localparam int AXIL_AW = 32;
  localparam int AXIL_DW = 32;

  localparam logic [1:0] RESP_OKAY    = 2'b00;
  localparam logic [1:0] RESP_EXOKAY  = 2'b01;
  localparam logic [1:0] RESP_SLVERR  = 2'b10;
  localparam logic [1:0] RESP_DECERR  = 2'b11;
  // An aborted transaction reports the DECERR encoding to the requester.
  localparam logic [1:0] RESP_TIMEOUT = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R,
    RSP
  } axil_mst_state_e;

  typedef struct packed {
    logic                 write;
    logic [AXIL_AW-1:0]   addr;
    logic [AXIL_DW-1:0]   wdata;
    logic [AXIL_DW/8-1:0] wstrb;
  } axil_cmd_t;

  typedef struct packed {
    logic               write;
    logic [AXIL_DW-1:0] rdata;
    logic [1:0]         resp;
  } axil_rsp_t;

endpackage

// File: rtl/axil_wdog.sv
// Wait-state watchdog for axil_master: counts enabled cycles since the last
// clear and flags expiry on the TIMEOUT_CYCLES-th one.
module axil_wdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic ACLK,
  input  logic ARESETn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/axil_master.sv
// AXI4-Lite initiator: one outstanding single-beat command, fully registered
// outputs. Define AXIL_MASTER_TIMEOUT_EN to add the wait-state abort watchdog.
module axil_master
  import axil_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic                    rsp_write,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [ADDR_WIDTH-1:0]   AWADDR,
  output logic                    AWVALID,
  input  logic                    AWREADY,
  output logic [DATA_WIDTH-1:0]   WDATA,
  output logic [DATA_WIDTH/8-1:0] WSTRB,
  output logic                    WVALID,
  input  logic                    WREADY,
  input  logic [1:0]              BRESP,
  input  logic                    BVALID,
  output logic                    BREADY,
  output logic [ADDR_WIDTH-1:0]   ARADDR,
  output logic                    ARVALID,
  input  logic                    ARREADY,
  input  logic [DATA_WIDTH-1:0]   RDATA,
  input  logic [1:0]              RRESP,
  input  logic                    RVALID,
  output logic                    RREADY,
  output logic                    timeout
);

  if (DATA_WIDTH != 32 || TIMEOUT_CYCLES < 2) begin : g_param_check
    $error("axil_master: DATA_WIDTH must be 32 and TIMEOUT_CYCLES at least 2");
  end

  axil_mst_state_e state, state_nxt;
  axil_rsp_t       rsp_q, rsp_nxt;

  logic                    awvalid_nxt, wvalid_nxt, bready_nxt, arvalid_nxt, rready_nxt;
  logic                    rsp_valid_nxt;
  logic [ADDR_WIDTH-1:0]   awaddr_nxt, araddr_nxt;
  logic [DATA_WIDTH-1:0]   wdata_nxt;
  logic [DATA_WIDTH/8-1:0] wstrb_nxt;
  logic                    wdog_expired;

  assign rsp_write = rsp_q.write;
  assign rsp_rdata = rsp_q.rdata;
  assign rsp_resp  = rsp_q.resp;

  // Next-state and next-output logic; every register holds unless a handshake moves it.
  always_comb begin
    state_nxt     = state;
    awvalid_nxt   = AWVALID;
    wvalid_nxt    = WVALID;
    bready_nxt    = BREADY;
    arvalid_nxt   = ARVALID;
    rready_nxt    = RREADY;
    rsp_valid_nxt = rsp_valid;
    rsp_nxt       = rsp_q;
    awaddr_nxt    = AWADDR;
    araddr_nxt    = ARADDR;
    wdata_nxt     = WDATA;
    wstrb_nxt     = WSTRB;

    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (cmd_write) begin
            awaddr_nxt  = cmd_addr;
            wdata_nxt   = cmd_wdata;
            wstrb_nxt   = cmd_wstrb;
            awvalid_nxt = 1'b1;
            wvalid_nxt  = 1'b1;
            state_nxt   = WR_AW_W;
          end else begin
            araddr_nxt  = cmd_addr;
            arvalid_nxt = 1'b1;
            state_nxt   = RD_AR;
          end
        end
      end
      WR_AW_W: begin
        awvalid_nxt = AWVALID && !AWREADY;
        wvalid_nxt  = WVALID && !WREADY;
        if (!awvalid_nxt && !wvalid_nxt) begin
          bready_nxt = 1'b1;
          state_nxt  = WR_B;
        end
      end
      WR_B: begin
        if (BVALID) begin
          bready_nxt    = 1'b0;
          rsp_nxt       = '{write: 1'b1, rdata: '0, resp: BRESP};
          rsp_valid_nxt = 1'b1;
          state_nxt     = RSP;
        end
      end
      RD_AR: begin
        if (ARREADY) begin
          arvalid_nxt = 1'b0;
          rready_nxt  = 1'b1;
          state_nxt   = RD_R;
        end
      end
      RD_R: begin
        if (RVALID) begin
          rready_nxt    = 1'b0;
          rsp_nxt       = '{write: 1'b0, rdata: RDATA, resp: RRESP};
          rsp_valid_nxt = 1'b1;
          state_nxt     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Abort drops every handshake signal without completing it.
    if (wdog_expired) begin
      awvalid_nxt   = 1'b0;
      wvalid_nxt    = 1'b0;
      bready_nxt    = 1'b0;
      arvalid_nxt   = 1'b0;
      rready_nxt    = 1'b0;
      rsp_nxt       = '{write: (state == WR_AW_W || state == WR_B), rdata: '0, resp: RESP_TIMEOUT};
      rsp_valid_nxt = 1'b1;
      state_nxt     = RSP;
    end
  end

  // cmd_ready mirrors the next state so it is low while reset is asserted.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state     <= IDLE;
      cmd_ready <= 1'b0;
      AWVALID   <= 1'b0;
      WVALID    <= 1'b0;
      BREADY    <= 1'b0;
      ARVALID   <= 1'b0;
      RREADY    <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_q     <= '0;
      AWADDR    <= '0;
      ARADDR    <= '0;
      WDATA     <= '0;
      WSTRB     <= '0;
    end else begin
      state     <= state_nxt;
      cmd_ready <= (state_nxt == IDLE);
      AWVALID   <= awvalid_nxt;
      WVALID    <= wvalid_nxt;
      BREADY    <= bready_nxt;
      ARVALID   <= arvalid_nxt;
      RREADY    <= rready_nxt;
      rsp_valid <= rsp_valid_nxt;
      rsp_q     <= rsp_nxt;
      AWADDR    <= awaddr_nxt;
      ARADDR    <= araddr_nxt;
      WDATA     <= wdata_nxt;
      WSTRB     <= wstrb_nxt;
    end
  end

`ifdef AXIL_MASTER_TIMEOUT_EN
  logic wait_state;

  assign wait_state = (state == WR_AW_W) || (state == WR_B) ||
                      (state == RD_AR) || (state == RD_R);

  axil_wdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdog (
    .ACLK   (ACLK),
    .ARESETn(ARESETn),
    .clear  (state_nxt != state),
    .enable (wait_state),
    .expired(wdog_expired)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      timeout <= 1'b0;
    end else if (wdog_expired) begin
      timeout <= 1'b1;
    end
  end
`else
  assign wdog_expired = 1'b0;
  assign timeout      = 1'b0;
`endif

endmodule

// File: tb/tb_axil_master.sv
// Self-checking bench for axil_master: behavioural AXI-Lite responder with
// randomised stalls plus a word-array reference model of the expected memory.
module tb_axil_master;

  logic        ACLK, ARESETn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_write;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY, timeout;
  logic [1:0]  BRESP, RRESP;

  axil_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .timeout(timeout)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Responder address map: 0x380-0x3FF DECERR, 0x300-0x37F SLVERR, rest OKAY.
  function automatic logic [1:0] addr_resp(input logic [31:0] a);
    if (a[9:7] == 3'b111) return 2'b11;
    if (a[9:7] == 3'b110) return 2'b10;
    return 2'b00;
  endfunction

  logic [31:0] model_mem [256];
  logic [31:0] resp_mem  [256];
  int          exp_b = 0;

  // Responder state, all updated on the falling edge.
  int          aw_delay = 0, w_delay = 0, ar_delay = 0;
  int          aw_wait, w_wait, ar_wait;
  bit          rand_mode = 0, ar_block = 0;
  bit          aw_have, w_have, rd_pending;
  bit          aw_fire, w_fire, b_fire, ar_fire, r_fire;
  logic [31:0] aw_addr, w_data, ar_addr;
  logic [3:0]  w_strb;
  int          b_count = 0, arvalid_cycles = 0;
  bit          saw_aw_only, saw_w_only;
  bit          prev_ok, prev_awv, prev_awr, prev_wv, prev_wr, prev_arv, prev_arr;
  logic [31:0] prev_awaddr, prev_wdata, prev_araddr;
  logic [3:0]  prev_wstrb;

  always begin : responder
    @(negedge ACLK);
    if (!ARESETn) begin
      AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0;
      ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
      aw_have = 0; w_have = 0; rd_pending = 0;
      aw_fire = 0; w_fire = 0; b_fire = 0; ar_fire = 0; r_fire = 0;
      aw_wait = 0; w_wait = 0; ar_wait = 0; prev_ok = 0;
    end else begin
      if (prev_ok) begin
        if (prev_awv && !prev_awr) checkOutput("aw_hold", {AWVALID, AWADDR}, {1'b1, prev_awaddr});
        if (prev_wv && !prev_wr) checkOutput("w_hold", {WVALID, WSTRB, WDATA}, {1'b1, prev_wstrb, prev_wdata});
        if (prev_arv && !prev_arr && !timeout) checkOutput("ar_hold", {ARVALID, ARADDR}, {1'b1, prev_araddr});
      end
      if (rsp_valid) checkOutput("no_new_valid", {AWVALID, WVALID, ARVALID}, 3'b000);
      if (AWVALID && !WVALID) saw_aw_only = 1;
      if (WVALID && !AWVALID) saw_w_only = 1;
      if (ARVALID) arvalid_cycles++;

      if (aw_fire) aw_have = 1;
      if (w_fire) w_have = 1;
      if (b_fire) BVALID = 0;
      if (r_fire) RVALID = 0;
      if (ar_fire) rd_pending = 1;

      if (aw_have && w_have && !BVALID) begin
        BRESP = addr_resp(aw_addr);
        if (BRESP == 2'b00)
          for (int b = 0; b < 4; b++)
            if (w_strb[b]) resp_mem[aw_addr[9:2]][8*b +: 8] = w_data[8*b +: 8];
        BVALID = 1; aw_have = 0; w_have = 0;
        if (rand_mode) begin
          aw_delay = $urandom_range(0, 3);
          w_delay  = $urandom_range(0, 3);
        end
      end
      if (rd_pending && !RVALID) begin
        RRESP = addr_resp(ar_addr);
        RDATA = (RRESP == 2'b00) ? resp_mem[ar_addr[9:2]] : 32'hE0E0_E0E0;
        RVALID = 1; rd_pending = 0;
        if (rand_mode) ar_delay = $urandom_range(0, 3);
      end

      AWREADY = AWVALID && !aw_have && (aw_wait >= aw_delay);
      if (AWVALID && !aw_have && !AWREADY) aw_wait++;
      WREADY = WVALID && !w_have && (w_wait >= w_delay);
      if (WVALID && !w_have && !WREADY) w_wait++;
      ARREADY = ARVALID && !rd_pending && !ar_block && (ar_wait >= ar_delay);
      if (ARVALID && !rd_pending && !ARREADY) ar_wait++;

      aw_fire = AWVALID && AWREADY;
      if (aw_fire) begin aw_addr = AWADDR; aw_wait = 0; end
      w_fire = WVALID && WREADY;
      if (w_fire) begin w_data = WDATA; w_strb = WSTRB; w_wait = 0; end
      ar_fire = ARVALID && ARREADY;
      if (ar_fire) begin ar_addr = ARADDR; ar_wait = 0; end
      b_fire = BVALID && BREADY;
      if (b_fire) b_count++;
      r_fire = RVALID && RREADY;

      prev_awv = AWVALID; prev_awr = AWREADY; prev_awaddr = AWADDR;
      prev_wv = WVALID; prev_wr = WREADY; prev_wdata = WDATA; prev_wstrb = WSTRB;
      prev_arv = ARVALID; prev_arr = ARREADY; prev_araddr = ARADDR;
      prev_ok = 1;
    end
  end

  task automatic sendCmd(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                         input logic [3:0] strb);
    int n;
    cmd_valid = 1; cmd_write = wr; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
    n = 0;
    while (!cmd_ready && n < 50) begin @(negedge ACLK); n++; end
    checkOutput("cmd_accept", cmd_ready, 1'b1);
    @(negedge ACLK);
    cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
  endtask

  task automatic waitRsp();
    int n;
    n = 0;
    while (!rsp_valid && n < 200) begin @(negedge ACLK); n++; end
    checkOutput("rsp_arrive", rsp_valid, 1'b1);
  endtask

  // One full command; the model predicts the response before it is issued.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int hold);
    logic [1:0]  e_resp;
    logic [31:0] e_rdata;
    logic [34:0] first;
    e_resp = addr_resp(addr);
    if (wr) begin
      e_rdata = 0;
      exp_b++;
      if (e_resp == 2'b00)
        for (int b = 0; b < 4; b++)
          if (strb[b]) model_mem[addr[9:2]][8*b +: 8] = data[8*b +: 8];
    end else begin
      e_rdata = (e_resp == 2'b00) ? model_mem[addr[9:2]] : 32'hE0E0_E0E0;
    end
    sendCmd(wr, addr, data, strb);
    waitRsp();
    first = {rsp_write, rsp_rdata, rsp_resp};
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      checkOutput("rsp_hold", {rsp_valid, rsp_write, rsp_rdata, rsp_resp}, {1'b1, first});
      checkOutput("cmd_ready_busy", cmd_ready, 1'b0);
    end
    checkOutput(wr ? "wr_rsp" : "rd_rsp", {rsp_write, rsp_resp, rsp_rdata}, {wr, e_resp, e_rdata});
    rsp_ready = 1;
    @(negedge ACLK);
    rsp_ready = 0;
    checkOutput("rsp_drop", rsp_valid, 1'b0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput(tag, {AWVALID, WVALID, BREADY, ARVALID, RREADY, rsp_valid, cmd_ready, timeout,
                      rsp_write, rsp_resp}, 0);
    checkOutput({tag, "_addr"}, {AWADDR, ARADDR}, 0);
    checkOutput({tag, "_data"}, {WSTRB, WDATA, rsp_rdata}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin model_mem[i] = 0; resp_mem[i] = 0; end
    ARESETn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    cmd_wstrb = 0; rsp_ready = 0;
    #31;
    checkAllZero("reset");
    #21 ARESETn = 1;
    @(negedge ACLK); @(negedge ACLK);
    checkOutput("idle_ready", cmd_ready, 1'b1);

    applyStimulus(1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    applyStimulus(0, 32'h10, 0, 0, 0);
    applyStimulus(1, 32'h20, 32'hFFFFFFFF, 4'hF, 0);
    applyStimulus(1, 32'h20, 32'h00001200, 4'b0010, 0);
    applyStimulus(0, 32'h20, 0, 0, 0);

    saw_aw_only = 0; saw_w_only = 0; aw_delay = 3; w_delay = 0;
    applyStimulus(1, 32'h30, 32'hA5A5_0001, 4'hF, 0);
    checkOutput("w_first_drop", {saw_aw_only, saw_w_only}, 2'b10);
    saw_aw_only = 0; saw_w_only = 0; aw_delay = 0; w_delay = 3;
    applyStimulus(1, 32'h34, 32'h5A5A_0002, 4'hF, 0);
    checkOutput("aw_first_drop", {saw_aw_only, saw_w_only}, 2'b01);
    w_delay = 0;
    applyStimulus(0, 32'h30, 0, 0, 0);
    applyStimulus(0, 32'h34, 0, 0, 0);

    applyStimulus(1, 32'h40, 32'h1234_5678, 4'hF, 10);
    applyStimulus(0, 32'h40, 0, 0, 10);
    applyStimulus(1, 32'h300, 32'h1111_2222, 4'hF, 0);
    applyStimulus(0, 32'h380, 0, 0, 0);

    for (int i = 0; i < 16; i++) applyStimulus(1, 32'(4 * i), 32'(i) * 32'h01010101, 4'hF, 0);
    for (int i = 0; i < 16; i++) applyStimulus(0, 32'(4 * i), 0, 0, 0);

    rand_mode = 1;
    for (int i = 0; i < 60; i++)
      applyStimulus(1'($urandom_range(0, 1)), {22'd0, 8'($urandom_range(0, 255)), 2'b00},
                    $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3));
    rand_mode = 0; aw_delay = 0; w_delay = 0; ar_delay = 0;
    @(negedge ACLK);
    checkOutput("b_count", b_count, exp_b);

`ifdef AXIL_MASTER_TIMEOUT_EN
    ar_block = 1; arvalid_cycles = 0;
    sendCmd(0, 32'h44, 0, 0);
    waitRsp();
    checkOutput("to_rsp", {ARVALID, rsp_resp, rsp_rdata}, {1'b0, 2'b11, 32'h0});
    checkOutput("to_flag", timeout, 1'b1);
    checkOutput("to_cycles", arvalid_cycles, 16);
    rsp_ready = 1; @(negedge ACLK); rsp_ready = 0;
    @(negedge ACLK);
    checkOutput("to_sticky", timeout, 1'b1);
    ar_block = 0;
`else
    checkOutput("timeout_tied", timeout, 1'b0);
`endif

    aw_delay = 20;
    sendCmd(1, 32'h50, 32'hCAFE_F00D, 4'hF);
    @(negedge ACLK); @(negedge ACLK);
    checkOutput("mid_aw_busy", AWVALID, 1'b1);
    #2 ARESETn = 0;
    #1 checkAllZero("mid_reset");
    @(negedge ACLK); @(negedge ACLK);
    #2 ARESETn = 1;
    aw_delay = 0;
    @(negedge ACLK); @(negedge ACLK);
    checkOutput("post_reset_ready", {cmd_ready, timeout}, 2'b10);
    applyStimulus(0, 32'h50, 0, 0, 0);
    applyStimulus(0, 32'h10, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
